// File: rtl/dk_sfx_sequencer.sv
// Sample-rate strobe generator and trigger sequencer for the discrete sound blocks.
// CPU latch levels become sample-aligned active-low enables with minimum on/off times.
module dk_sfx_sequencer #(
  parameter int CLOCK_RATE  = 768000,
  parameter int SAMPLE_RATE = 48000,
  parameter int NUM_CH      = 3,
  parameter int MIN_ON      = 4,
  parameter int MIN_OFF     = 8
) (
  input  logic              clk,
  input  logic              I_RSTn,
  input  logic [NUM_CH-1:0] trig,
  output logic              audio_clk_en,
  output logic [NUM_CH-1:0] sfx_en_n,
  output logic [NUM_CH-1:0] busy
);

  localparam int DIV     = CLOCK_RATE / SAMPLE_RATE;
  localparam int DIV_W   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int REM_MAX = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int REM_W   = ($clog2(REM_MAX) > 0) ? $clog2(REM_MAX) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(DIV - 2);
  localparam logic [REM_W-1:0] ON_LOAD  = REM_W'(MIN_ON - 1);
  localparam logic [REM_W-1:0] OFF_LOAD = REM_W'(MIN_OFF - 1);
  localparam logic [REM_W-1:0] REM_ZERO = {REM_W{1'b0}};
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ON      = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  logic [DIV_W-1:0]  div_cnt_r;
  logic              strobe_r;
  logic [NUM_CH-1:0] trig_q_r;
  logic [NUM_CH-1:0] pending_r;
  logic [NUM_CH-1:0] en_n_r;
  logic [NUM_CH-1:0] busy_r;
  state_t            state_r [NUM_CH];
  logic [REM_W-1:0]  rem_r [NUM_CH];

  logic [NUM_CH-1:0] edge_s;
  logic [NUM_CH-1:0] consume_s;
  logic [NUM_CH-1:0] pending_next_s;
  state_t            state_next_s [NUM_CH];
  logic [REM_W-1:0]  rem_next_s [NUM_CH];

  assign audio_clk_en = strobe_r;
  assign sfx_en_n     = en_n_r;
  assign busy         = busy_r;

  // Channel next-state and one-deep request queue; FSMs advance only in strobe cycles.
  always_comb begin
    edge_s    = trig & ~trig_q_r;
    consume_s = {NUM_CH{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      state_next_s[ch] = state_r[ch];
      rem_next_s[ch]   = rem_r[ch];
      if (strobe_r) begin
        case (state_r[ch])
          ST_IDLE: begin
            if (pending_r[ch]) begin
              state_next_s[ch] = ST_ON;
              rem_next_s[ch]   = ON_LOAD;
              consume_s[ch]    = 1'b1;
            end else begin
              state_next_s[ch] = ST_IDLE;
            end
          end
          ST_ON: begin
            if (rem_r[ch] != REM_ZERO) begin
              rem_next_s[ch] = rem_r[ch] - REM_ONE;
            end else if (!trig[ch]) begin
              state_next_s[ch] = ST_HOLDOFF;
              rem_next_s[ch]   = OFF_LOAD;
            end else begin
              state_next_s[ch] = ST_ON;
            end
          end
          ST_HOLDOFF: begin
            if (rem_r[ch] != REM_ZERO) begin
              rem_next_s[ch] = rem_r[ch] - REM_ONE;
            end else if (pending_r[ch]) begin
              state_next_s[ch] = ST_ON;
              rem_next_s[ch]   = ON_LOAD;
              consume_s[ch]    = 1'b1;
            end else begin
              state_next_s[ch] = ST_IDLE;
            end
          end
          default: begin
            state_next_s[ch] = ST_IDLE;
            rem_next_s[ch]   = REM_ZERO;
          end
        endcase
      end else begin
        state_next_s[ch] = state_r[ch];
      end
    end
    // A fresh edge in a consume cycle must survive, so it is OR-ed in last.
    pending_next_s = (pending_r & ~consume_s) | edge_s;
  end

  // Divider, strobe, edge history, channel state and next-state-decoded outputs.
  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      div_cnt_r <= {DIV_W{1'b0}};
      strobe_r  <= 1'b0;
      trig_q_r  <= {NUM_CH{1'b0}};
      pending_r <= {NUM_CH{1'b0}};
      en_n_r    <= {NUM_CH{1'b1}};
      busy_r    <= {NUM_CH{1'b0}};
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_r[ch] <= ST_IDLE;
        rem_r[ch]   <= REM_ZERO;
      end
    end else begin
      div_cnt_r <= (div_cnt_r == DIV_LAST) ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
      strobe_r  <= (div_cnt_r == DIV_PRE);
      trig_q_r  <= trig;
      pending_r <= pending_next_s;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_r[ch] <= state_next_s[ch];
        rem_r[ch]   <= rem_next_s[ch];
        en_n_r[ch]  <= (state_next_s[ch] != ST_ON);
        busy_r[ch]  <= (state_next_s[ch] != ST_IDLE) | pending_next_s[ch];
      end
    end
  end

endmodule

// File: tb/tb_dk_sfx_sequencer.sv
// Self-checking bench for dk_sfx_sequencer: sample-count reference model compared every
// cycle, plus directed scenarios with hand-computed timing expectations.
module tb_dk_sfx_sequencer;

  localparam int DIV     = 16;
  localparam int MIN_ON  = 4;
  localparam int MIN_OFF = 8;
  localparam int NCH     = 3;

  logic           clk;
  logic           rst_n;
  logic [NCH-1:0] trig;
  logic           audio_clk_en;
  logic [NCH-1:0] sfx_en_n;
  logic [NCH-1:0] busy;

  int n_checks = 0;
  int n_fail   = 0;

  dk_sfx_sequencer #(
    .CLOCK_RATE (768000),
    .SAMPLE_RATE(48000),
    .NUM_CH     (NCH),
    .MIN_ON     (MIN_ON),
    .MIN_OFF    (MIN_OFF)
  ) dut (
    .clk         (clk),
    .I_RSTn      (rst_n),
    .trig        (trig),
    .audio_clk_en(audio_clk_en),
    .sfx_en_n    (sfx_en_n),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts elapsed samples since activation / deactivation.
  bit             model_valid = 1'b0;
  int             cyc;
  bit [NCH-1:0]   m_prev, m_pend, m_active, m_cool;
  int             m_cnt [NCH];
  logic           exp_strobe;
  logic [NCH-1:0] exp_en_n, exp_busy;

  always @(posedge clk) begin
    bit           stb, take;
    bit [NCH-1:0] edges;
    if (!rst_n) begin
      cyc = 0; m_prev = '0; m_pend = '0; m_active = '0; m_cool = '0;
      for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
      model_valid = 1'b1;
    end else begin
      stb   = ((cyc % DIV) == DIV - 1);
      edges = trig & ~m_prev;
      for (int c = 0; c < NCH; c++) begin
        take = 1'b0;
        if (stb) begin
          if (m_active[c]) begin
            m_cnt[c]++;
            if (m_cnt[c] >= MIN_ON && !trig[c]) begin
              m_active[c] = 1'b0; m_cool[c] = 1'b1; m_cnt[c] = 0;
            end
          end else if (m_cool[c]) begin
            m_cnt[c]++;
            if (m_cnt[c] >= MIN_OFF) begin
              m_cool[c] = 1'b0;
              take = m_pend[c];
            end
          end else begin
            take = m_pend[c];
          end
          if (take) begin
            m_active[c] = 1'b1; m_cnt[c] = 0; m_pend[c] = 1'b0;
          end
        end
      end
      m_pend = m_pend | edges;
      m_prev = trig;
      cyc++;
    end
    exp_strobe = rst_n ? ((cyc % DIV) == DIV - 1) : 1'b0;
    exp_en_n   = ~m_active;
    exp_busy   = m_active | m_cool | m_pend;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_audio_clk_en", audio_clk_en, exp_strobe);
      chk("model_sfx_en_n", sfx_en_n, exp_en_n);
      chk("model_busy", busy, exp_busy);
    end
  end

  task automatic pulse(input int ch);
    trig[ch] = 1'b1;
    @(negedge clk);
    trig[ch] = 1'b0;
  endtask

  task automatic wait_fall(input int ch, input string name);
    int n = 0;
    while (sfx_en_n[ch] !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk(name, (n < 64), 1'b1);
  endtask

  task automatic run_len(input int ch, input logic lvl, input int budget, output int n);
    n = 0;
    while (sfx_en_n[ch] === lvl && n < budget) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic busy_len(input int ch, output int n);
    n = 0;
    while (busy[ch] === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 3'b000 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(name, (n < 600), 1'b1);
  endtask

  task automatic find_strobes(input string name);
    int first = -1;
    int second = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (audio_clk_en === 1'b1) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    chk({name, "_first"}, first, 15);
    chk({name, "_second"}, second, 31);
  endtask

  initial begin
    int n, s, lows;
    rst_n = 1'b0;
    trig  = 3'b000;
    repeat (3) @(negedge clk);
    chk("reset_en_n", sfx_en_n, 3'b111);
    chk("reset_busy", busy, 3'b000);
    chk("reset_strobe", audio_clk_en, 1'b0);
    rst_n = 1'b1;
    find_strobes("first_strobe");

    // Short pulse: exactly MIN_ON samples low, then MIN_OFF samples busy in holdoff.
    pulse(0);
    wait_fall(0, "short_fall_timeout");
    chk("short_others_high", sfx_en_n[2:1], 2'b11);
    run_len(0, 1'b0, 300, n);
    chk("short_low_len", n, 64);
    busy_len(0, n);
    chk("short_holdoff_busy", n, 128);

    // Retrigger two samples into holdoff.
    pulse(0);
    wait_fall(0, "retrig_fall_timeout");
    run_len(0, 1'b0, 300, n);
    chk("retrig_low1", n, 64);
    n = 0;
    while (sfx_en_n[0] === 1'b1 && n < 300) begin
      if (n == 32) trig[0] = 1'b1;
      if (n == 33) trig[0] = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("retrig_high", n, 128);
    run_len(0, 1'b0, 300, n);
    chk("retrig_low2", n, 64);
    wait_idle("retrig_idle_timeout");

    // Coalescing: three edges during ON, then an edge in the consume cycle.
    pulse(1);
    wait_fall(1, "coal_fall_timeout");
    n = 0;
    while (sfx_en_n[1] === 1'b0 && n < 300) begin
      if (n == 5 || n == 10 || n == 15) trig[1] = 1'b1;
      if (n == 6 || n == 11 || n == 16) trig[1] = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("coal_low1", n, 64);
    n = 0; s = 0;
    while (sfx_en_n[1] === 1'b1 && n < 300) begin
      if (audio_clk_en === 1'b1) begin
        s++;
        if (s == 8) trig[1] = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    trig[1] = 1'b0;
    chk("coal_high1", n, 128);
    run_len(1, 1'b0, 300, n);
    chk("coal_low2", n, 64);
    run_len(1, 1'b1, 300, n);
    chk("coal_high2", n, 128);
    run_len(1, 1'b0, 300, n);
    chk("coal_low3", n, 64);
    run_len(1, 1'b1, 400, n);
    chk("coal_no_more", n, 400);

    // Concurrency with the edge landing in a strobe cycle.
    n = 0;
    while (audio_clk_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    trig = 3'b111;
    @(negedge clk);
    trig = 3'b100;
    n = 1;
    while (sfx_en_n !== 3'b000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("conc_latency", n, 17);
    chk("conc_all_low", sfx_en_n, 3'b000);
    run_len(0, 1'b0, 300, n);
    chk("conc_ch0_low", n, 64);
    chk("conc_ch2_held", sfx_en_n[2], 1'b0);
    repeat (100) @(negedge clk);
    trig[2] = 1'b0;
    wait_idle("conc_idle_timeout");

    // Long hold (walk pattern).
    trig[0] = 1'b1;
    lows = 0;
    for (int k = 0; k < 1500 * DIV; k++) begin
      @(negedge clk);
      if (sfx_en_n[0] === 1'b0) lows++;
    end
    trig[0] = 1'b0;
    run_len(0, 1'b0, 100, n);
    lows = lows + n;
    chk("long_low_range", (lows >= 1500 * DIV - DIV) && (lows <= 1500 * DIV + DIV), 1'b1);
    busy_len(0, n);
    chk("long_holdoff_busy", n, 128);

    // Reset in the middle of ON.
    pulse(0);
    wait_fall(0, "rst_fall_timeout");
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midon_rst_en_n", sfx_en_n, 3'b111);
    chk("midon_rst_busy", busy, 3'b000);
    chk("midon_rst_strobe", audio_clk_en, 1'b0);
    rst_n = 1'b1;
    find_strobes("post_rst_strobe");
    lows = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sfx_en_n !== 3'b111) lows++;
    end
    chk("post_rst_quiet", lows, 0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      rst_n = ($urandom_range(1999, 0) == 0) ? 1'b0 : 1'b1;
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(39, 0) == 0) trig[c] = ~trig[c];
      end
    end
    rst_n = 1'b1;
    trig  = 3'b000;
    repeat (500) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
